misr_bus_driver: RTL and testbench
==================================

MISR_BUS_DRIVER -- requirements
Module: misr_bus_driver

Interface
REQ-001 Parameter NBIT_DATA, default 64: bus data width.
REQ-002 Parameter NBIT_ADDR, default 64: bus address width.
REQ-003 Parameter START_ADDR, default 2**25: MISR peripheral base address.
REQ-004 Parameter NUM_SAMPLES, default 64: stream transactions per run (range 1..65535).
REQ-005 Parameter POLL_MAX, default 16: DONE-register polls before timeout (range 1..255).
REQ-006 clk_i  in  1: single clock; all state updates on rising edge.
REQ-007 rst_ni  in  1: asynchronous, active-low reset.
REQ-008 start_i  in  1: run request, sampled in IDLE only.
REQ-009 coeff_i  in  NBIT_DATA: MISR polynomial coefficients, captured on accepted start.
REQ-010 seed_i  in  NBIT_DATA: stimulus LFSR seed, captured on accepted start; zero replaced by 1.
REQ-011 golden_i  in  NBIT_DATA: expected signature, captured on accepted start.
REQ-012 req_o  out  1: bus request.
REQ-013 we_o  out  1: bus write enable.
REQ-014 addr_o  out  NBIT_ADDR: bus address.
REQ-015 data_o  out  NBIT_DATA: bus write data.
REQ-016 rdata_i  in  NBIT_DATA: peripheral read data, valid the cycle after a read request.
REQ-017 busy_o  out  1: high from accepted start until the cycle done_o pulses.
REQ-018 done_o  out  1: one-cycle pulse at run end.
REQ-019 pass_o  out  1: captured signature equals golden; held until next accepted start.
REQ-020 timeout_o  out  1: DONE poll exhausted; held until next accepted start.
REQ-021 signature_o  out  NBIT_DATA: last captured signature, held.

Function
REQ-022 FSM states: IDLE, CFG_CTRL, CFG_COEF, STREAM, POLL_REQ, POLL_WAIT, SIG_REQ, SIG_WAIT, FINISH.
REQ-023 IDLE: req_o=0; start_i=1 captures inputs, clears pass_o/timeout_o, goes to CFG_CTRL next cycle.
REQ-024 CFG_CTRL: one cycle req_o=1, we_o=1, addr_o=START_ADDR+0x00, data_o=0x3 (enable + MISR reset).
REQ-025 CFG_COEF: one cycle req_o=1, we_o=1, addr_o=START_ADDR+0x40, data_o=captured coeff.
REQ-026 STREAM: NUM_SAMPLES consecutive cycles with req_o=1, we_o=0, data_o=LFSR state, addr_o=LFSR state AND (START_ADDR-1); LFSR advances every stream cycle.
REQ-027 Stream addresses never fall inside [START_ADDR, START_ADDR+0xFF].
REQ-028 POLL_REQ: one cycle req_o=1, we_o=0, addr_o=START_ADDR+0xC0; then POLL_WAIT.
REQ-029 POLL_WAIT: req_o=0; rdata_i[0]=1 -> SIG_REQ; else poll counter +1; counter reaching POLL_MAX -> timeout_o=1, FINISH; else POLL_REQ.
REQ-030 SIG_REQ: one cycle req_o=1, we_o=0, addr_o=START_ADDR+0x80; then SIG_WAIT.
REQ-031 SIG_WAIT: capture rdata_i into signature_o; pass_o=(rdata_i==golden); then FINISH.
REQ-032 FINISH: done_o=1 for one cycle, busy_o=0 in that cycle, return to IDLE.
REQ-033 Best-case latency start_i to done_o: NUM_SAMPLES+7 cycles.
REQ-034 Outside request cycles req_o, we_o, addr_o, data_o are 0.
REQ-035 start_i while busy_o=1 is ignored; pass_o and timeout_o never both 1.
REQ-036 Stream counter width is clog2(NUM_SAMPLES+1); no wrap within a run.
REQ-037 LFSR: 64-bit Galois, taps x^64+x^63+x^61+x^60+1, shift right.

Reset
REQ-038 rst_ni=0 forces IDLE and all outputs to 0 immediately, including mid-run; no bus transaction completes after assertion.
REQ-039 Counters, captured inputs and LFSR reset to 0; first run after reset behaves identically to any other.

Structure
REQ-040 Package misr_pkg holds register offsets (CONTROL 0x00, COEFFICIENTS 0x40, SIGNATURE 0x80, DONE 0xC0), control bit positions and the FSM state enum.
REQ-041 Sub-module lfsr64 (load, enable, seed, state) provides stimulus; all else in misr_bus_driver.

Verification
REQ-042 Start with coeff=0x1B, seed=0x1, NUM_SAMPLES=4, responder DONE=1 immediately -> write 0x3 @0x2000000, write 0x1B @0x2000040, 4 reads below 0x2000000, read @0x20000C0, read @0x2000080, done_o at cycle 11.
REQ-043 Responder signature 0xDEADBEEF, golden 0xDEADBEEF -> pass_o=1, signature_o=0xDEADBEEF; golden 0x0 -> pass_o=0.
REQ-044 Responder DONE=0 always, POLL_MAX=16 -> exactly 16 DONE reads, timeout_o=1, pass_o=0, done_o pulse.
REQ-045 rst_ni deasserted for one cycle during STREAM -> req_o=0 same cycle, FSM IDLE, new start runs full sequence.
REQ-046 start_i held high throughout a run -> exactly one sequence, second run begins only after return to IDLE.
REQ-047 seed_i=0 -> LFSR loads 1, stream data non-zero and matches reference model.

Source files
------------

// File: rtl/misr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : misr_pkg
// Description : Register map, control bits and FSM states shared by the
//               MISR bus driver.
// Revision    : 1.0
// ============================================================================
package misr_pkg;

    localparam logic [7:0] c_reg_control      = 8'h00;
    localparam logic [7:0] c_reg_coefficients = 8'h40;
    localparam logic [7:0] c_reg_signature    = 8'h80;
    localparam logic [7:0] c_reg_done         = 8'hC0;

    localparam int c_ctrl_enable_bit     = 0;
    localparam int c_ctrl_misr_reset_bit = 1;
    localparam int c_done_bit            = 0;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG_CTRL  = 4'd1,
        S_CFG_COEF  = 4'd2,
        S_STREAM    = 4'd3,
        S_POLL_REQ  = 4'd4,
        S_POLL_WAIT = 4'd5,
        S_SIG_REQ   = 4'd6,
        S_SIG_WAIT  = 4'd7,
        S_FINISH    = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/misr_bus_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : misr_bus_driver_if
// Description : Simple request/write-enable bus between driver and MISR.
// Revision    : 1.0
// ============================================================================
interface misr_bus_driver_if #(
    parameter int NBIT_DATA = 64,
    parameter int NBIT_ADDR = 64
);
    logic                 req;
    logic                 we;
    logic [NBIT_ADDR-1:0] addr;
    logic [NBIT_DATA-1:0] data;
    logic [NBIT_DATA-1:0] rdata;

    modport master (output req, output we, output addr, output data, input rdata);
    modport slave  (input req, input we, input addr, input data, output rdata);
endinterface
`default_nettype wire

// File: rtl/lfsr64.sv
`default_nettype none
// ============================================================================
// Module      : lfsr64
// Description : 64-bit right-shifting Galois LFSR, x^64+x^63+x^61+x^60+1.
// Revision    : 1.0
// ============================================================================
module lfsr64 (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        load,
    input  wire logic        enable,
    input  wire logic [63:0] seed,
    output logic      [63:0] state
);
    localparam logic [63:0] c_taps = 64'hD800_0000_0000_0000;

    logic [63:0] r_state;

    // An all-zero state would lock up, so a zero seed loads 1 instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= (seed == 64'd0) ? 64'd1 : seed;
        end else if (enable) begin
            r_state <= r_state[0] ? ((r_state >> 1) ^ c_taps) : (r_state >> 1);
        end
    end

    assign state = r_state;
endmodule
`default_nettype wire

// File: rtl/misr_bus_driver.sv
`default_nettype none
// ============================================================================
// Module      : misr_bus_driver
// Description : Configures a MISR peripheral, streams LFSR stimulus, polls
//               DONE, reads the signature and compares against golden.
// Revision    : 1.0
// ============================================================================
module misr_bus_driver
    import misr_pkg::*;
#(
    parameter int                   NBIT_DATA   = 64,
    parameter int                   NBIT_ADDR   = 64,
    parameter logic [NBIT_ADDR-1:0] START_ADDR  = NBIT_ADDR'(2**25),
    parameter int                   NUM_SAMPLES = 64,
    parameter int                   POLL_MAX    = 16
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic                 start_i,
    input  wire logic [NBIT_DATA-1:0] coeff_i,
    input  wire logic [NBIT_DATA-1:0] seed_i,
    input  wire logic [NBIT_DATA-1:0] golden_i,
    misr_bus_driver_if.master         bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [NBIT_DATA-1:0]      signature_o
);
    localparam int                   c_cnt_w     = $clog2(NUM_SAMPLES + 1);
    localparam logic [NBIT_ADDR-1:0] c_addr_ctrl = START_ADDR + NBIT_ADDR'(c_reg_control);
    localparam logic [NBIT_ADDR-1:0] c_addr_coef = START_ADDR + NBIT_ADDR'(c_reg_coefficients);
    localparam logic [NBIT_ADDR-1:0] c_addr_sig  = START_ADDR + NBIT_ADDR'(c_reg_signature);
    localparam logic [NBIT_ADDR-1:0] c_addr_done = START_ADDR + NBIT_ADDR'(c_reg_done);
    localparam logic [NBIT_ADDR-1:0] c_addr_mask = START_ADDR - NBIT_ADDR'(1);
    localparam logic [NBIT_DATA-1:0] c_ctrl_word = (NBIT_DATA'(1) << c_ctrl_enable_bit)
                                                 | (NBIT_DATA'(1) << c_ctrl_misr_reset_bit);

    state_e               r_state, w_next_state;
    logic [NBIT_DATA-1:0] r_coeff, r_golden, r_signature;
    logic [c_cnt_w-1:0]   r_stream_cnt;
    logic [7:0]           r_poll_cnt;
    logic [7:0]           w_poll_inc;
    logic                 r_pass, r_timeout;
    logic                 w_start_accept;
    logic [63:0]          w_lfsr_state;
    logic                 w_req, w_we;
    logic [NBIT_ADDR-1:0] w_addr;
    logic [NBIT_DATA-1:0] w_data;

    assign w_start_accept = (r_state == S_IDLE) && start_i;
    assign w_poll_inc     = r_poll_cnt + 8'd1;

    lfsr64 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (w_start_accept),
        .enable (r_state == S_STREAM),
        .seed   (64'(seed_i)),
        .state  (w_lfsr_state)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        case (r_state)
            S_IDLE:      if (start_i) w_next_state = S_CFG_CTRL;
            S_CFG_CTRL: begin
                {w_req, w_we} = 2'b11;
                w_addr        = c_addr_ctrl;
                w_data        = c_ctrl_word;
                w_next_state  = S_CFG_COEF;
            end
            S_CFG_COEF: begin
                {w_req, w_we} = 2'b11;
                w_addr        = c_addr_coef;
                w_data        = r_coeff;
                w_next_state  = S_STREAM;
            end
            S_STREAM: begin
                // Masking with START_ADDR-1 keeps stimulus below the register window.
                w_req  = 1'b1;
                w_addr = NBIT_ADDR'(w_lfsr_state) & c_addr_mask;
                w_data = NBIT_DATA'(w_lfsr_state);
                if (r_stream_cnt == c_cnt_w'(NUM_SAMPLES - 1)) w_next_state = S_POLL_REQ;
            end
            S_POLL_REQ: begin
                w_req        = 1'b1;
                w_addr       = c_addr_done;
                w_next_state = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (bus.rdata[c_done_bit])           w_next_state = S_SIG_REQ;
                else if (w_poll_inc == 8'(POLL_MAX)) w_next_state = S_FINISH;
                else                                 w_next_state = S_POLL_REQ;
            end
            S_SIG_REQ: begin
                w_req        = 1'b1;
                w_addr       = c_addr_sig;
                w_next_state = S_SIG_WAIT;
            end
            S_SIG_WAIT:  w_next_state = S_FINISH;
            S_FINISH:    w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_coeff      <= '0;
            r_golden     <= '0;
            r_signature  <= '0;
            r_stream_cnt <= '0;
            r_poll_cnt   <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_start_accept) begin
                r_coeff      <= coeff_i;
                r_golden     <= golden_i;
                r_stream_cnt <= '0;
                r_poll_cnt   <= '0;
                r_pass       <= 1'b0;
                r_timeout    <= 1'b0;
            end
            if (r_state == S_STREAM) r_stream_cnt <= r_stream_cnt + c_cnt_w'(1);
            if (r_state == S_POLL_WAIT && !bus.rdata[c_done_bit]) begin
                r_poll_cnt <= w_poll_inc;
                if (w_poll_inc == 8'(POLL_MAX)) r_timeout <= 1'b1;
            end
            if (r_state == S_SIG_WAIT) begin
                r_signature <= bus.rdata;
                r_pass      <= (bus.rdata == r_golden);
            end
        end
    end

    assign bus.req     = w_req;
    assign bus.we      = w_we;
    assign bus.addr    = w_addr;
    assign bus.data    = w_data;
    assign busy_o      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done_o      = (r_state == S_FINISH);
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign signature_o = r_signature;
endmodule
`default_nettype wire

// File: tb/tb_misr_bus_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_misr_bus_driver
// Description : Scoreboard bench: expected bus transactions and run results
//               are queued by the stimulus and checked by a negedge monitor.
// Revision    : 1.0
// ============================================================================
module tb_misr_bus_driver;
    localparam int          NS   = 4;
    localparam int          PM   = 16;
    localparam logic [63:0] BASE = 64'h0200_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] coeff, seed, golden;
    logic        busy, done, pass, tmo;
    logic [63:0] sig;

    always #5 clk = ~clk;

    misr_bus_driver_if #(.NBIT_DATA(64), .NBIT_ADDR(64)) bus ();

    misr_bus_driver #(
        .NBIT_DATA(64), .NBIT_ADDR(64), .START_ADDR(BASE),
        .NUM_SAMPLES(NS), .POLL_MAX(PM)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .coeff_i(coeff), .seed_i(seed), .golden_i(golden),
        .bus(bus),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .timeout_o(tmo), .signature_o(sig)
    );

    typedef struct { logic we; logic [63:0] addr; logic [63:0] data; } txn_t;
    typedef struct { logic pass; logic tmo; logic [63:0] sig; } res_t;
    txn_t exp_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        done_flag;
    logic [63:0] sig_val;

    // Hand-computed LFSR sequences for seed 1 (also seed 0) and seed 3.
    logic [63:0] seq_s1 [4] = '{64'h1, 64'hD800_0000_0000_0000,
                                64'h6C00_0000_0000_0000, 64'h3600_0000_0000_0000};
    logic [63:0] seq_s3 [4] = '{64'h3, 64'hD800_0000_0000_0001,
                                64'hB400_0000_0000_0000, 64'h5A00_0000_0000_0000};

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Peripheral model: read data appears the cycle after a read request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rdata <= '0;
        else begin
            bus.rdata <= '0;
            if (bus.req && !bus.we) begin
                if (bus.addr == BASE + 64'hC0)      bus.rdata <= {63'd0, done_flag};
                else if (bus.addr == BASE + 64'h80) bus.rdata <= sig_val;
            end
        end
    end

    always @(negedge clk) begin
        txn_t t;
        res_t r;
        if (rst_n === 1'b1) begin
            if (bus.req === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_txn actual we=%b addr=%h required none", bus.we, bus.addr);
                end else begin
                    t = exp_q.pop_front();
                    check64("txn_we",   {63'd0, bus.we}, {63'd0, t.we});
                    check64("txn_addr", bus.addr, t.addr);
                    check64("txn_data", bus.data, t.data);
                end
            end
            if (done === 1'b1) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    r = res_q.pop_front();
                    check64("pass",      {63'd0, pass}, {63'd0, r.pass});
                    check64("timeout",   {63'd0, tmo},  {63'd0, r.tmo});
                    check64("signature", sig, r.sig);
                    check64("busy_at_done", {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    task automatic push_txn(input logic we, input logic [63:0] addr, input logic [63:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        exp_q.push_back(t);
    endtask

    task automatic push_run(input logic [63:0] c, input logic [63:0] tbl [4], input int polls,
                            input bit sig_read, input logic p, input logic to, input logic [63:0] s);
        res_t r;
        push_txn(1'b1, BASE, 64'h3);
        push_txn(1'b1, BASE + 64'h40, c);
        for (int i = 0; i < NS; i++) push_txn(1'b0, tbl[i] & (BASE - 64'd1), tbl[i]);
        for (int i = 0; i < polls; i++) push_txn(1'b0, BASE + 64'hC0, 64'd0);
        if (sig_read) push_txn(1'b0, BASE + 64'h80, 64'd0);
        r.pass = p; r.tmo = to; r.sig = s;
        res_q.push_back(r);
    endtask

    task automatic do_run(input logic [63:0] sd, input logic [63:0] c, input logic [63:0] g,
                          input bit hold_start, input int exp_lat);
        bit found;
        found = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; seed = sd; coeff = c; golden = g;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        check64("busy_after_start", {63'd0, busy}, 64'd1);
        for (int n = 1; n < 300; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                check64("latency", 64'(n), 64'(exp_lat));
                break;
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL done_wait actual=none required=pulse");
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; coeff = '0; seed = '0; golden = '0;
        done_flag = 1'b1; sig_val = 64'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_req",  {63'd0, bus.req}, 64'd0);
        check64("rst_busy", {63'd0, busy}, 64'd0);
        check64("rst_done", {63'd0, done}, 64'd0);
        check64("rst_pass", {63'd0, pass}, 64'd0);
        check64("rst_tmo",  {63'd0, tmo},  64'd0);
        check64("rst_sig",  sig, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Matching golden, DONE ready on first poll.
        push_run(64'h1B, seq_s1, 1, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF);
        do_run(64'h1, 64'h1B, 64'hDEAD_BEEF, 1'b0, NS + 7);

        // Mismatching golden with a different seed and coefficient.
        push_run(64'h5A5A, seq_s3, 1, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF);
        do_run(64'h3, 64'h5A5A, 64'h0, 1'b0, NS + 7);

        // DONE never set: POLL_MAX polls, timeout, signature unchanged.
        done_flag = 1'b0;
        push_run(64'h1B, seq_s1, PM, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF);
        do_run(64'h1, 64'h1B, 64'hDEAD_BEEF, 1'b0, NS + 3 + 2 * PM);
        done_flag = 1'b1;

        // Zero seed with start held high for the whole run.
        push_run(64'hC3, seq_s1, 1, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF);
        do_run(64'h0, 64'hC3, 64'hDEAD_BEEF, 1'b1, NS + 7);
        repeat (3) @(posedge clk);
        #1;
        check64("idle_after_hold", {63'd0, busy}, 64'd0);

        // Reset asserted in the first STREAM cycle.
        push_txn(1'b1, BASE, 64'h3);
        push_txn(1'b1, BASE + 64'h40, 64'h77);
        start = 1'b1; seed = 64'h1; coeff = 64'h77;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check64("midrst_req",  {63'd0, bus.req}, 64'd0);
        check64("midrst_busy", {63'd0, busy}, 64'd0);
        check64("midrst_pass", {63'd0, pass}, 64'd0);
        check64("midrst_sig",  sig, 64'd0);
        check64("midrst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        push_run(64'h1B, seq_s1, 1, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF);
        do_run(64'h1, 64'h1B, 64'hDEAD_BEEF, 1'b0, NS + 7);

        repeat (2) @(posedge clk);
        #1;
        check64("txn_queue_empty", 64'(exp_q.size()), 64'd0);
        check64("res_queue_empty", 64'(res_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
